// File: rtl/product_accumulator.sv
// Saturating dot-product accumulator fed by a sequential multiplier.
// A rising edge on done captures one signed product; TERMS products form one result.
module product_accumulator #(
  parameter int PROD_W = 14,
  parameter int ACC_W  = 20,
  parameter int TERMS  = 6,
  parameter int CNT_W  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic signed [PROD_W-1:0] product,
  input  logic                     done,
  output logic signed [ACC_W-1:0]  acc_out,
  output logic        [CNT_W-1:0]  term_count,
  output logic                     acc_valid,
  output logic                     overflow,
  output logic                     busy
);

  typedef enum logic [1:0] {COLLECT, ADD, FULL} state_t;

  localparam logic [CNT_W-1:0]       TERMS_C = CNT_W'(TERMS);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                     r_state, w_next;
  logic                       r_done_q;
  logic                       r_pending;
  logic signed [PROD_W-1:0]   r_prod_q;
  logic signed [PROD_W-1:0]   r_pend_prod;
  logic                       w_edge;
  logic signed [ACC_W:0]      w_sum;
  logic        [CNT_W-1:0]    w_cnt_inc;

  assign w_edge    = done & ~r_done_q;
  assign w_cnt_inc = term_count + 1'b1;
  // One guard bit: the two top bits disagree exactly when the sum left the ACC_W range.
  assign w_sum     = {acc_out[ACC_W-1], acc_out}
                   + {{(ACC_W+1-PROD_W){r_prod_q[PROD_W-1]}}, r_prod_q};
  assign acc_valid = (r_state == FULL);
  assign busy      = (r_state == ADD);

  always_comb begin
    w_next = r_state;
    if (clear) begin
      w_next = COLLECT;
    end else begin
      case (r_state)
        COLLECT: if (w_edge || r_pending) w_next = ADD;
        ADD:     w_next = (w_cnt_inc == TERMS_C) ? FULL : COLLECT;
        FULL:    w_next = FULL;
        default: w_next = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= COLLECT;
    else       r_state <= w_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_out     <= '0;
      term_count  <= '0;
      overflow    <= 1'b0;
      r_done_q    <= 1'b1;
      r_pending   <= 1'b0;
      r_prod_q    <= '0;
      r_pend_prod <= '0;
    end else begin
      r_done_q <= done;
      if (clear) begin
        acc_out    <= '0;
        term_count <= '0;
        overflow   <= 1'b0;
        r_pending  <= 1'b0;
      end else begin
        case (r_state)
          COLLECT: begin
            // Held product is older, so it goes first; a fresh edge refills the slot.
            if (r_pending) begin
              r_prod_q  <= r_pend_prod;
              r_pending <= w_edge;
              if (w_edge) r_pend_prod <= product;
            end else if (w_edge) begin
              r_prod_q <= product;
            end
          end
          ADD: begin
            if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
              acc_out  <= w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
              overflow <= 1'b1;
            end else begin
              acc_out <= w_sum[ACC_W-1:0];
            end
            term_count <= w_cnt_inc;
            if (w_edge && !r_pending) begin
              r_pending   <= 1'b1;
              r_pend_prod <= product;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Randomized self-checking bench: two configurations (20-bit/6 terms, 14-bit/3 terms)
// compared against an integer model of the accumulate/saturate/count rules.
module tb_product_accumulator;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [1:0]         clr = '0;
  logic [1:0]         dn  = '0;
  logic [13:0]        prod = '0;
  logic signed [19:0] a_acc;
  logic signed [13:0] b_acc;
  logic [3:0]         a_cnt, b_cnt;
  logic               a_vld, b_vld, a_ovf, b_ovf, a_busy, b_busy;

  int n_vec = 0;
  int n_err = 0;
  int m_acc[2];
  int m_cnt[2];
  int m_ovf[2];

  always #5 clk = ~clk;

  product_accumulator #(.PROD_W(14), .ACC_W(20), .TERMS(6), .CNT_W(4)) u_a (
    .clock(clk), .reset(rst), .clear(clr[0]), .product(prod), .done(dn[0]),
    .acc_out(a_acc), .term_count(a_cnt), .acc_valid(a_vld), .overflow(a_ovf), .busy(a_busy));

  product_accumulator #(.PROD_W(14), .ACC_W(14), .TERMS(3), .CNT_W(4)) u_b (
    .clock(clk), .reset(rst), .clear(clr[1]), .product(prod), .done(dn[1]),
    .acc_out(b_acc), .term_count(b_cnt), .acc_valid(b_vld), .overflow(b_ovf), .busy(b_busy));

  function automatic int terms_of(int s); return (s != 0) ? 3 : 6; endfunction

  function automatic void m_clear(int s);
    m_acc[s] = 0; m_cnt[s] = 0; m_ovf[s] = 0;
  endfunction

  // Reference: plain integer sum clamped to the accumulator range, ignored once full.
  function automatic void m_add(int s, int p);
    int aw, hi, lo, sum;
    if (m_cnt[s] == terms_of(s)) return;
    aw  = (s != 0) ? 14 : 20;
    hi  = (1 << (aw - 1)) - 1;
    lo  = -(1 << (aw - 1));
    sum = m_acc[s] + p;
    if (sum > hi) begin sum = hi; m_ovf[s] = 1; end
    if (sum < lo) begin sum = lo; m_ovf[s] = 1; end
    m_acc[s] = sum;
    m_cnt[s] = m_cnt[s] + 1;
  endfunction

  function automatic int obs_f(int s, int f);
    case (f)
      0: return (s != 0) ? int'(b_acc) : int'(a_acc);
      1: return (s != 0) ? int'(b_cnt) : int'(a_cnt);
      2: return (s != 0) ? int'(b_vld) : int'(a_vld);
      default: return (s != 0) ? int'(b_ovf) : int'(a_ovf);
    endcase
  endfunction

  function automatic int exp_f(int s, int f);
    case (f)
      0: return m_acc[s];
      1: return m_cnt[s];
      2: return (m_cnt[s] == terms_of(s)) ? 1 : 0;
      default: return m_ovf[s];
    endcase
  endfunction

  // One multiplier completion: done high one cycle, result visible two edges later.
  task automatic drive(int s, int p);
    @(negedge clk); prod = 14'(p); dn[s] = 1'b1;
    @(negedge clk); dn[s] = 1'b0;
    @(negedge clk);
    m_add(s, p);
  endtask

  task automatic pulse_clear(int s);
    @(negedge clk); clr[s] = 1'b1;
    @(negedge clk); clr[s] = 1'b0;
    m_clear(s);
  endtask

  task automatic test_reset;
    dn = 2'b11;
    repeat (3) @(negedge clk);
    m_clear(0); m_clear(1);
    for (int s = 0; s < 2; s++)
      for (int f = 0; f < 4; f++) begin
        n_vec++;
        if (obs_f(s, f) !== 0) begin
          n_err++; $display("FAIL reset_val s=%0d f=%0d got=%0d exp=0", s, f, obs_f(s, f));
        end
      end
    n_vec++;
    if ({a_busy, b_busy} !== 2'b00) begin
      n_err++; $display("FAIL reset_busy got=%b exp=00", {a_busy, b_busy});
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    for (int f = 0; f < 2; f++) begin
      n_vec++;
      if (obs_f(0, f) !== 0) begin
        n_err++; $display("FAIL done_high_at_release f=%0d got=%0d exp=0", f, obs_f(0, f));
      end
    end
    dn = 2'b00;
    drive(0, 40);
    for (int f = 0; f < 2; f++) begin
      n_vec++;
      if (obs_f(0, f) !== exp_f(0, f)) begin
        n_err++; $display("FAIL first_edge f=%0d got=%0d exp=%0d", f, obs_f(0, f), exp_f(0, f));
      end
    end
  endtask

  task automatic test_dot_product;
    int prods[6] = '{40, 40, -10, 1, 1, -55};
    pulse_clear(0);
    foreach (prods[i]) drive(0, prods[i]);
    n_vec++;
    if (a_acc !== 20'h00011) begin
      n_err++; $display("FAIL dot_acc got=%h exp=00011", a_acc);
    end
    for (int f = 1; f < 4; f++) begin
      n_vec++;
      if (obs_f(0, f) !== exp_f(0, f)) begin
        n_err++; $display("FAIL dot f=%0d got=%0d exp=%0d", f, obs_f(0, f), exp_f(0, f));
      end
    end
  endtask

  task automatic test_full_ignore;
    drive(0, 100);
    for (int f = 0; f < 4; f++) begin
      n_vec++;
      if (obs_f(0, f) !== exp_f(0, f)) begin
        n_err++; $display("FAIL full_ignore f=%0d got=%0d exp=%0d", f, obs_f(0, f), exp_f(0, f));
      end
    end
    pulse_clear(0);
    for (int f = 0; f < 4; f++) begin
      n_vec++;
      if (obs_f(0, f) !== exp_f(0, f)) begin
        n_err++; $display("FAIL clear f=%0d got=%0d exp=%0d", f, obs_f(0, f), exp_f(0, f));
      end
    end
  endtask

  task automatic test_saturation;
    int vals[2] = '{4096, -4032};
    foreach (vals[v]) begin
      pulse_clear(1);
      repeat (3) drive(1, vals[v]);
      for (int f = 0; f < 4; f++) begin
        n_vec++;
        if (obs_f(1, f) !== exp_f(1, f)) begin
          n_err++; $display("FAIL sat v=%0d f=%0d got=%0d exp=%0d", vals[v], f, obs_f(1, f), exp_f(1, f));
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    pulse_clear(0);
    @(negedge clk); prod = 14'(7); dn[0] = 1'b1;
    @(negedge clk); dn[0] = 1'b0;
    n_vec++;
    if (a_busy !== 1'b1) begin
      n_err++; $display("FAIL b2b_busy got=%b exp=1", a_busy);
    end
    @(negedge clk); prod = 14'(-3); dn[0] = 1'b1;
    @(negedge clk); dn[0] = 1'b0;
    @(negedge clk);
    m_add(0, 7); m_add(0, -3);
    for (int f = 0; f < 2; f++) begin
      n_vec++;
      if (obs_f(0, f) !== exp_f(0, f)) begin
        n_err++; $display("FAIL b2b f=%0d got=%0d exp=%0d", f, obs_f(0, f), exp_f(0, f));
      end
    end
    @(negedge clk); clr[0] = 1'b1; prod = 14'(9); dn[0] = 1'b1;
    @(negedge clk); clr[0] = 1'b0;
    repeat (3) @(negedge clk);
    dn[0] = 1'b0;
    m_clear(0);
    for (int f = 0; f < 2; f++) begin
      n_vec++;
      if (obs_f(0, f) !== exp_f(0, f)) begin
        n_err++; $display("FAIL clear_edge f=%0d got=%0d exp=%0d", f, obs_f(0, f), exp_f(0, f));
      end
    end
  endtask

  task automatic test_async_reset;
    drive(0, 11);
    @(negedge clk); prod = 14'(5); dn[0] = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (a_busy !== 1'b1 || a_acc !== 20'sd11) begin
      n_err++; $display("FAIL pre_reset busy=%b acc=%0d exp busy=1 acc=11", a_busy, a_acc);
    end
    #1 rst = 1'b1;
    #1;
    m_clear(0); m_clear(1);
    for (int f = 0; f < 4; f++) begin
      n_vec++;
      if (obs_f(0, f) !== exp_f(0, f)) begin
        n_err++; $display("FAIL async_reset f=%0d got=%0d exp=%0d", f, obs_f(0, f), exp_f(0, f));
      end
    end
    n_vec++;
    if (a_busy !== 1'b0) begin
      n_err++; $display("FAIL async_busy got=%b exp=0", a_busy);
    end
    dn[0] = 1'b0;
    @(negedge clk); rst = 1'b0;
    drive(0, 5);
    for (int f = 0; f < 2; f++) begin
      n_vec++;
      if (obs_f(0, f) !== exp_f(0, f)) begin
        n_err++; $display("FAIL after_reset f=%0d got=%0d exp=%0d", f, obs_f(0, f), exp_f(0, f));
      end
    end
  endtask

  task automatic test_random;
    for (int s = 0; s < 2; s++)
      for (int r = 0; r < 4; r++) begin
        pulse_clear(s);
        for (int k = 0; k <= terms_of(s); k++) begin
          drive(s, int'($urandom_range(0, 16383)) - 8192);
          for (int f = 0; f < 4; f++) begin
            n_vec++;
            if (obs_f(s, f) !== exp_f(s, f)) begin
              n_err++;
              $display("FAIL rand s=%0d r=%0d k=%0d f=%0d got=%0d exp=%0d",
                       s, r, k, f, obs_f(s, f), exp_f(s, f));
            end
          end
        end
      end
  endtask

  initial begin
    test_reset;
    test_dot_product;
    test_full_ignore;
    test_saturation;
    test_back_to_back;
    test_async_reset;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
